// File: rtl/mau_pkg.sv
// Shared types and lane helpers for the memory access unit: size encodings,
// FSM states and little-endian sub-word merge/extract functions.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } mau_state_e;

    // Replace only the addressed lane of old_word with the low bits of wdata.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{off, 3'b000} +: 8]      = wdata[7:0];
            SZ_HALF: w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: w                          = wdata;
            default: w                          = old_word;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sign & b[7]}}, b};
            SZ_HALF: r = {{16{sign & h[15]}}, h};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Combinational lane unit: merges store data into an old word and extracts
// extended load data from a word, both little-endian.
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    always_comb begin
        merged    = lane_merge(old_word, wdata, size, off);
        extracted = lane_extract(old_word, size, off, sign);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator for the word-wide data memory. Sub-word
// stores are read-modify-write; one single-cycle response per accepted request.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [31:0]      req_pc,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [31:0]      resp_rdata,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      dm_pc,
    output logic             dm_wEn,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_dIn,
    input  logic [31:0]      dm_dOut
);

    mau_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             sign_q, sign_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      pc_q, pc_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      din_q, din_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             req_err;
    logic [31:0]      lane_merged;
    logic [31:0]      lane_extracted;

    mau_lane u_lane (
        .old_word  (dm_dOut),
        .wdata     (wdata_q),
        .size      (size_q),
        .off       (addr_q[1:0]),
        .sign      (sign_q),
        .merged    (lane_merged),
        .extracted (lane_extracted)
    );

    // Only feeds next-state logic, so no req_* to output combinational path.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)                                 req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])               req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    req_err = 1'b1;
        if (req_addr >= DM_LIMIT)                             req_err = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sign_d    = sign_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pc_d      = pc_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        din_d     = din_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sign_d  = req_sign;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    err_d   = req_err;
                    rdata_d = '0;
                    din_d   = '0;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_we) begin
                        state_d = StRead;
                    end else if (req_size == SZ_WORD) begin
                        din_d   = req_wdata;
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (!we_q) begin
                    rdata_d = lane_extracted;
                    state_d = StResp;
                end else begin
                    din_d   = lane_merged;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            sign_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            din_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            din_q     <= din_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // dm_wEn is decoded from state, so the async reset removes it at once.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid & err_q;
        resp_rdata = resp_valid ? rdata_q : '0;
        dm_wEn     = (state_q == StWrite);
        dm_addr    = {addr_q[31:2], 2'b00};
        dm_dIn     = din_q;
        dm_pc      = pc_q;
        err_cnt    = err_cnt_q;
    end

endmodule
